lmsm_sequencer: RTL and testbench
=================================

// Module: lmsm_sequencer
// PURPOSE
//  ID-stage micro-op sequencer for LM/SM (load/store-multiple): expands one instruction into one
//  load/store micro-op per set bit of its 8-bit register mask, lowest register first.
//  Freezes PC and IF/ID while sequencing, and yields to the load-hazard stall and to pipeline flush.
//  Sits between the IF/ID register and the ID/EX register, alongside the load-hazard unit.
// PARAMETERS
//  ADDR_W     16  address / base-register width
//  NREGS      8   register-mask width (one bit per GPR)
//  IDX_W      3   register index width, log2(NREGS)
//  ADDR_STEP  1   address increment per micro-op (word-addressed memory)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  instr_valid    in   1       IF/ID holds a valid instruction
//  is_lm          in   1       decoded LM (wins if is_sm is also set)
//  is_sm          in   1       decoded SM
//  reg_mask       in   NREGS   register mask from instruction imm field
//  base_addr      in   ADDR_W  RA value (already forwarded)
//  hold_in        in   1       load-hazard stall; freezes sequencer
//  flush          in   1       branch/jump flush from EX; aborts sequence
//  pc_enable      out  1       PC write enable
//  if_id_enable   out  1       IF/ID write enable
//  bubble_out     out  1       insert NOP into ID/EX this cycle
//  busy           out  1       sequence in progress (state SEQ)
//  uop_valid      out  1       micro-op presented to ID/EX
//  uop_is_load    out  1       1 = LM micro-op, 0 = SM micro-op
//  uop_reg        out  IDX_W   destination (LM) / source (SM) register
//  uop_addr       out  ADDR_W  memory address of micro-op
//  uop_last       out  1       final micro-op of sequence
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, mask_q=0, addr_q=0, kind_q=0.
//   Outputs: pc_enable=1, if_id_enable=1, bubble_out=0, busy=0, uop_valid=0, uop_last=0.
//  FSM states: IDLE, SEQ.
//  start = IDLE & instr_valid & (is_lm|is_sm) & !hold_in & !flush.
//  IDLE, start, reg_mask!=0:
//   - latch mask_q=reg_mask, addr_q=base_addr, kind_q=is_lm; next state SEQ.
//   - this cycle: pc_enable=0, if_id_enable=0, bubble_out=1, uop_valid=0.
//  IDLE, start, reg_mask==0: NOP. bubble_out=1 for one cycle, no stall, stay IDLE.
//  IDLE otherwise: all enables 1, uop_valid=0.
//  SEQ: outputs are a combinational decode of the state registers.
//   - uop_valid=1, uop_reg=index of lowest set bit of mask_q, uop_addr=addr_q, uop_is_load=kind_q.
//   - uop_last=1 iff mask_q has exactly one bit set.
//  SEQ advance (!hold_in & !flush): clear lowest bit of mask_q; addr_q += ADDR_STEP.
//   - Address arithmetic is mod 2^ADDR_W (0xFFFF+1 -> 0x0000).
//   - On uop_last, next state IDLE.
//  SEQ enables: pc_enable = if_id_enable = uop_last & !hold_in.
//   - Next instruction enters ID the cycle after the last micro-op.
//  Latency: first micro-op 1 cycle after start; N set bits take N+1 ID cycles in total.
//  hold_in=1 in SEQ: state, mask_q and addr_q frozen; outputs held steady; pc/if_id enables 0.
//  flush=1 (any state): next state IDLE, mask_q cleared, uop_valid=0 from the next cycle.
//   - flush has priority over hold_in and start; enables are 1 during the flush cycle.
//  Reset mid-sequence: immediate IDLE; the partial sequence is discarded.
// TESTING
//  1. LM mask=0xA5, base=0x0100 -> start bubble; then uops reg 0,2,5,7 at addr 0x0100..0x0103.
//     uop_last on the 4th uop; pc_enable=0 for 4 cycles and 1 on the last.
//  2. SM mask=0x00 -> single bubble_out pulse, no uop_valid, pc_enable stays 1.
//  3. SM mask=0xC0, base=0xFFFF -> uops reg6@0xFFFF, reg7@0x0000 (wrap); uop_is_load=0.
//  4. LM mask=0x0F, hold_in=1 for 2 cycles at 2nd uop -> reg1@base+1 held 3 cycles.
//     Sequence completes with 4 uops total.
//  5. LM mask=0xFF, flush at 3rd uop -> next cycle uop_valid=0, busy=0, enables=1.
//     A new LM is accepted the following cycle.
//  6. rst_n=0 asynchronously mid-sequence -> outputs at reset values before the next clk edge.
//     No uop emitted after release until a new start.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// LM/SM micro-op sequencer for the ID stage: expands a register mask into
// one load/store micro-op per set bit, lowest register first.
module lmsm_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int NREGS     = 8,
    parameter int IDX_W     = 3,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic              is_lm,
    input  logic              is_sm,
    input  logic [NREGS-1:0]  reg_mask,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold_in,
    input  logic              flush,
    output logic              pc_enable,
    output logic              if_id_enable,
    output logic              bubble_out,
    output logic              busy,
    output logic              uop_valid,
    output logic              uop_is_load,
    output logic [IDX_W-1:0]  uop_reg,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              uop_last
);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t            state_q, state_d;
    logic [NREGS-1:0]  mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              kind_q, kind_d;

    logic              start;
    logic              one_left;
    logic [NREGS-1:0]  mask_rest;
    logic [IDX_W-1:0]  low_idx;

    // mask_rest drops the lowest set bit; empty rest means this is the last uop
    assign mask_rest = mask_q & (mask_q - NREGS'(1));
    assign one_left  = (mask_q != '0) && (mask_rest == '0);
    assign start     = (state_q == IDLE) && instr_valid && (is_lm || is_sm)
                       && !hold_in && !flush;

    always_comb begin
        low_idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = IDX_W'(i);
        end
    end

    assign uop_reg     = low_idx;
    assign uop_addr    = addr_q;
    assign uop_is_load = kind_q;
    assign busy        = (state_q == SEQ);
    assign uop_valid   = (state_q == SEQ);
    assign uop_last    = (state_q == SEQ) && one_left;

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        addr_d       = addr_q;
        kind_d       = kind_q;
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        bubble_out   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bubble_out = 1'b1;
                    if (reg_mask != '0) begin
                        mask_d       = reg_mask;
                        addr_d       = base_addr;
                        kind_d       = is_lm;
                        state_d      = SEQ;
                        pc_enable    = 1'b0;
                        if_id_enable = 1'b0;
                    end
                end
            end
            SEQ: begin
                pc_enable    = one_left && !hold_in;
                if_id_enable = one_left && !hold_in;
                if (flush) begin
                    pc_enable    = 1'b1;
                    if_id_enable = 1'b1;
                    mask_d       = '0;
                    state_d      = IDLE;
                end else if (!hold_in) begin
                    mask_d = mask_rest;
                    addr_d = addr_q + ADDR_W'(ADDR_STEP);
                    if (one_left) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            kind_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            kind_q  <= kind_d;
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, is_lm, is_sm, hold_in, flush;
    logic [7:0]  reg_mask;
    logic [15:0] base_addr;
    logic        pc_enable, if_id_enable, bubble_out, busy;
    logic        uop_valid, uop_is_load, uop_last;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: pending micro-ops as queues
    bit          m_busy;
    bit          m_kind;
    int          q_reg[$];
    logic [15:0] q_addr[$];

    lmsm_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .is_lm(is_lm), .is_sm(is_sm),
        .reg_mask(reg_mask), .base_addr(base_addr),
        .hold_in(hold_in), .flush(flush),
        .pc_enable(pc_enable), .if_id_enable(if_id_enable),
        .bubble_out(bubble_out), .busy(busy),
        .uop_valid(uop_valid), .uop_is_load(uop_is_load),
        .uop_reg(uop_reg), .uop_addr(uop_addr), .uop_last(uop_last)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0;
        m_kind = 0;
        q_reg.delete();
        q_addr.delete();
    endfunction

    // compare DUT against the model for the current inputs, then advance the model
    task automatic compare_and_advance();
        bit st, nz, last;
        int k;
        if (!m_busy) begin
            st = instr_valid && (is_lm || is_sm) && !hold_in && !flush;
            nz = (reg_mask != 0);
            chk("bubble_out", 32'(bubble_out), 32'(st));
            chk("pc_enable", 32'(pc_enable), 32'(!(st && nz)));
            chk("if_id_enable", 32'(if_id_enable), 32'(!(st && nz)));
            chk("busy", 32'(busy), 0);
            chk("uop_valid", 32'(uop_valid), 0);
            chk("uop_last", 32'(uop_last), 0);
            if (st && nz) begin
                k = 0;
                for (int i = 0; i < 8; i++) begin
                    if (reg_mask[i]) begin
                        q_reg.push_back(i);
                        q_addr.push_back(base_addr + 16'(k));
                        k++;
                    end
                end
                m_kind = is_lm;
                m_busy = 1;
            end
        end else begin
            last = (q_reg.size() == 1);
            chk("bubble_out", 32'(bubble_out), 0);
            chk("busy", 32'(busy), 1);
            chk("uop_valid", 32'(uop_valid), 1);
            chk("uop_reg", 32'(uop_reg), 32'(q_reg[0]));
            chk("uop_addr", 32'(uop_addr), 32'(q_addr[0]));
            chk("uop_is_load", 32'(uop_is_load), 32'(m_kind));
            chk("uop_last", 32'(uop_last), 32'(last));
            chk("pc_enable", 32'(pc_enable), 32'(flush || (last && !hold_in)));
            chk("if_id_enable", 32'(if_id_enable), 32'(flush || (last && !hold_in)));
            if (flush) begin
                model_reset();
            end else if (!hold_in) begin
                void'(q_reg.pop_front());
                void'(q_addr.pop_front());
                if (q_reg.size() == 0) m_busy = 0;
            end
        end
    endtask

    task automatic step(input bit iv, input bit lm, input bit sm,
                        input logic [7:0] m, input logic [15:0] b,
                        input bit h, input bit f);
        @(negedge clk);
        instr_valid = iv; is_lm = lm; is_sm = sm;
        reg_mask = m; base_addr = b; hold_in = h; flush = f;
        #1;
        compare_and_advance();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 8'h00, 16'h0000, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 0; is_lm = 0; is_sm = 0;
        reg_mask = 0; base_addr = 0; hold_in = 0; flush = 0;
        model_reset();
        #12;
        chk("rst pc_enable", 32'(pc_enable), 1);
        chk("rst if_id_enable", 32'(if_id_enable), 1);
        chk("rst busy", 32'(busy), 0);
        chk("rst uop_valid", 32'(uop_valid), 0);
        chk("rst uop_last", 32'(uop_last), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: LM 0xA5 @0x0100
        step(1, 1, 0, 8'hA5, 16'h0100, 0, 0);
        chk("t1 start bubble", 32'(bubble_out), 1);
        chk("t1 start pc", 32'(pc_enable), 0);
        idle_step();
        chk("t1 u0 reg", 32'(uop_reg), 0);
        chk("t1 u0 addr", 32'(uop_addr), 32'h0100);
        chk("t1 u0 pc", 32'(pc_enable), 0);
        idle_step();
        chk("t1 u1 reg", 32'(uop_reg), 2);
        idle_step();
        chk("t1 u2 reg", 32'(uop_reg), 5);
        chk("t1 u2 last", 32'(uop_last), 0);
        idle_step();
        chk("t1 u3 reg", 32'(uop_reg), 7);
        chk("t1 u3 addr", 32'(uop_addr), 32'h0103);
        chk("t1 u3 last", 32'(uop_last), 1);
        chk("t1 u3 pc", 32'(pc_enable), 1);
        idle_step();
        chk("t1 done busy", 32'(busy), 0);

        // 2: SM empty mask
        step(1, 0, 1, 8'h00, 16'h1234, 0, 0);
        chk("t2 bubble", 32'(bubble_out), 1);
        chk("t2 pc", 32'(pc_enable), 1);
        idle_step();
        chk("t2 no uop", 32'(uop_valid), 0);

        // 3: SM 0xC0 @0xFFFF wraps
        step(1, 0, 1, 8'hC0, 16'hFFFF, 0, 0);
        idle_step();
        chk("t3 u0 reg", 32'(uop_reg), 6);
        chk("t3 u0 addr", 32'(uop_addr), 32'hFFFF);
        chk("t3 u0 load", 32'(uop_is_load), 0);
        idle_step();
        chk("t3 u1 reg", 32'(uop_reg), 7);
        chk("t3 u1 addr", 32'(uop_addr), 32'h0000);
        chk("t3 u1 last", 32'(uop_last), 1);
        idle_step();

        // 4: LM 0x0F with two hold cycles on the 2nd uop
        step(1, 1, 0, 8'h0F, 16'h0200, 0, 0);
        idle_step();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 8'h00, 16'h0000, i < 2, 0);
            chk("t4 held reg", 32'(uop_reg), 1);
            chk("t4 held addr", 32'(uop_addr), 32'h0201);
            chk("t4 held pc", 32'(pc_enable), 0);
        end
        idle_step();
        idle_step();
        chk("t4 last reg", 32'(uop_reg), 3);
        chk("t4 last", 32'(uop_last), 1);
        idle_step();
        chk("t4 done", 32'(busy), 0);

        // 5: LM 0xFF flushed at 3rd uop, then a new LM
        step(1, 1, 0, 8'hFF, 16'h0300, 0, 0);
        idle_step();
        idle_step();
        step(0, 0, 0, 8'h00, 16'h0000, 0, 1);
        chk("t5 flush reg", 32'(uop_reg), 2);
        chk("t5 flush pc", 32'(pc_enable), 1);
        idle_step();
        chk("t5 after valid", 32'(uop_valid), 0);
        chk("t5 after busy", 32'(busy), 0);
        chk("t5 after pc", 32'(pc_enable), 1);
        step(1, 1, 0, 8'h03, 16'h0400, 0, 0);
        chk("t5 restart bubble", 32'(bubble_out), 1);
        idle_step();
        chk("t5 new u0 addr", 32'(uop_addr), 32'h0400);
        idle_step();
        idle_step();

        // 6: async reset mid-sequence
        step(1, 1, 0, 8'hFF, 16'h0500, 0, 0);
        idle_step();
        idle_step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 rst busy", 32'(busy), 0);
        chk("t6 rst valid", 32'(uop_valid), 0);
        chk("t6 rst pc", 32'(pc_enable), 1);
        chk("t6 rst last", 32'(uop_last), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle_step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, m, 16'($urandom),
                 $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
